// File: rtl/lb_write_sequencer_if.sv
// Local-bus write port driven by lb_write_sequencer toward the vmod1 register space.
interface lb_write_sequencer_if;
  logic [14:0] lb_addr;
  logic [31:0] lb_data;
  logic        lb_write;

  modport master (output lb_addr, output lb_data, output lb_write);
  modport slave  (input  lb_addr, input  lb_data, input  lb_write);
endinterface

// File: rtl/lb_write_sequencer.sv
// Replays a stored list of local-bus writes (with stall and end markers)
// into the vmod1 register space at a fixed write cadence.
module lb_write_sequencer #(
  parameter int unsigned AW         = 8,
  parameter int unsigned GAP        = 3,
  parameter logic [14:0] STALL_ADDR = 15'd555,
  parameter logic [14:0] END_ADDR   = 15'h7fff
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        ld_addr_i,
  input  logic [14:0]          ld_lb_addr_i,
  input  logic [31:0]          ld_lb_data_i,
  input  logic                 ld_write_i,
  output logic                 ld_reject_o,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          wr_count_o,
  lb_write_sequencer_if.master lb
);

  // GAP below 3 cannot be met by the RD/EX/WAIT loop, so it is clamped.
  localparam int unsigned GAP_EFF  = (GAP < 3) ? 3 : GAP;
  localparam logic [31:0] WAIT_CYC = 32'(GAP_EFF - 2);
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_EX    = 3'd2,
    S_WAIT  = 3'd3,
    S_STALL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic [14:0]   lb_addr_q, lb_addr_d;
  logic [31:0]   lb_data_q, lb_data_d;
  logic          lb_write_q, lb_write_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ld_reject_q, ld_reject_d;

  logic [46:0]   ram_q [0:(1 << AW) - 1];
  logic [46:0]   rd_q;
  logic [14:0]   ent_addr;
  logic [31:0]   ent_data;

  assign ent_addr = rd_q[46:32];
  assign ent_data = rd_q[31:0];

  // Program RAM: loads only while idle, registered read of the entry at ptr in RD; not reset.
  always_ff @(posedge clk) begin
    if (ld_write_i && (state_q == S_IDLE)) begin
      ram_q[ld_addr_i] <= {ld_lb_addr_i, ld_lb_data_i};
    end
    if (state_q == S_RD) begin
      rd_q <= ram_q[ptr_q];
    end else begin
      rd_q <= rd_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= 32'd0;
      last_q      <= 1'b0;
      wr_count_q  <= 16'd0;
      lb_addr_q   <= 15'd0;
      lb_data_q   <= 32'd0;
      lb_write_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ld_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      wr_count_q  <= wr_count_d;
      lb_addr_q   <= lb_addr_d;
      lb_data_q   <= lb_data_d;
      lb_write_q  <= lb_write_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ld_reject_q <= ld_reject_d;
    end
  end

  // Next-state and next-output logic; abort overrides everything and leaves counters/bus held.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    wr_count_d  = wr_count_q;
    lb_addr_d   = lb_addr_q;
    lb_data_d   = lb_data_q;
    lb_write_d  = 1'b0;
    ld_reject_d = ld_write_i && (state_q != S_IDLE);

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d    = S_RD;
            ptr_d      = '0;
            wr_count_d = 16'd0;
            last_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RD: begin
          state_d = S_EX;
        end
        S_EX: begin
          last_d = (ptr_q == PTR_LAST);
          if (ent_addr == END_ADDR) begin
            state_d = S_DONE;
          end else begin
            // The pointer parks on the last entry so a full table never wraps.
            if (ptr_q != PTR_LAST) begin
              ptr_d = ptr_q + AW'(1);
            end else begin
              ptr_d = ptr_q;
            end
            if (ent_addr == STALL_ADDR) begin
              cnt_d = ent_data;
              if (ent_data != 32'd0) begin
                state_d = S_STALL;
              end else if (ptr_q == PTR_LAST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_RD;
              end
            end else begin
              lb_addr_d  = ent_addr;
              lb_data_d  = ent_data;
              lb_write_d = 1'b1;
              cnt_d      = WAIT_CYC;
              state_d    = S_WAIT;
              if (wr_count_q != 16'hffff) begin
                wr_count_d = wr_count_q + 16'd1;
              end else begin
                wr_count_d = wr_count_q;
              end
            end
          end
        end
        S_WAIT, S_STALL: begin
          if (cnt_q <= 32'd1) begin
            if (last_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RD;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign ld_reject_o = ld_reject_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wr_count_o  = wr_count_q;
  assign lb.lb_addr  = lb_addr_q;
  assign lb.lb_data  = lb_data_q;
  assign lb.lb_write = lb_write_q;

endmodule

// File: tb/tb_lb_write_sequencer.sv
// Self-checking bench for lb_write_sequencer (AW=3, GAP=3): table vectors,
// hand-written corner sequences and randomized programs against a schedule model.
module tb_lb_write_sequencer;

  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;
  localparam int          GAPV  = 3;
  localparam logic [14:0] STALL = 15'd555;
  localparam logic [14:0] ENDA  = 15'h7fff;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ld_addr_i;
  logic [14:0]   ld_lb_addr_i;
  logic [31:0]   ld_lb_data_i;
  logic          ld_write_i;
  logic          ld_reject_o;
  logic          start_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   wr_count_o;

  lb_write_sequencer_if lb_if ();

  lb_write_sequencer #(.AW(AW), .GAP(GAPV)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_addr_i    (ld_addr_i),
    .ld_lb_addr_i (ld_lb_addr_i),
    .ld_lb_data_i (ld_lb_data_i),
    .ld_write_i   (ld_write_i),
    .ld_reject_o  (ld_reject_o),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wr_count_o   (wr_count_o),
    .lb           (lb_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench view of the program RAM.
  logic [46:0] prog [DEPTH];

  // Model expectations.
  int exp_cyc[$];
  logic [14:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int exp_done, exp_last_busy, exp_wr, exp_rej;
  int prev_wr = 0;

  // Observations.
  int obs_cyc[$];
  logic [14:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int obs_done[$];
  int obs_rej[$];
  int busy_bad, hold_bad;

  typedef struct {
    logic [14:0] mid_addr;
    logic [31:0] mid_data;
    int          n_wr;
    int          last_wr_cyc;
    int          done_cyc;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [14:0] a, input logic [31:0] d);
    ld_addr_i    = AW'(idx);
    ld_lb_addr_i = a;
    ld_lb_data_i = d;
    ld_write_i   = 1'b1;
    @(posedge clk); #1;
    ld_write_i   = 1'b0;
    prog[idx]    = {a, d};
  endtask

  // Schedule model: walks the program entry by entry with the cycle rules
  // (write strobe at EX+1, next RD at EX+GAP-1 for writes and EX+N+1 for stalls).
  task automatic model(input int abort_at, input int misuse_at, input logic [46:0] mis_ent);
    int t, r;
    logic [14:0] a;
    logic [31:0] d;
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    if (misuse_at == 0) prog[0] = mis_ent;
    exp_done = -1;
    exp_rej  = -1;
    if (abort_at == 0) begin
      exp_last_busy = 0;
      exp_wr        = prev_wr;
    end else begin
      t = 2;
      for (int i = 0; i < DEPTH; i++) begin
        a = prog[i][46:32];
        d = prog[i][31:0];
        if (a == ENDA) begin
          exp_done = t + 1;
          break;
        end
        if (a == STALL) begin
          r = t + int'(d) + 1;
        end else begin
          exp_cyc.push_back(t + 1);
          exp_addr.push_back(a);
          exp_data.push_back(d);
          r = t + GAPV - 1;
        end
        if (i == DEPTH - 1) exp_done = r;
        else t = r + 1;
      end
      exp_last_busy = exp_done;
      if (abort_at > 0 && abort_at < exp_done) begin
        exp_done      = -1;
        exp_last_busy = abort_at;
        while (exp_cyc.size() > 0 && exp_cyc[exp_cyc.size()-1] > abort_at) begin
          void'(exp_cyc.pop_back());
          void'(exp_addr.pop_back());
          void'(exp_data.pop_back());
        end
      end
      exp_wr = exp_cyc.size();
      if (misuse_at >= 1 && misuse_at <= exp_last_busy) exp_rej = misuse_at + 1;
    end
    prev_wr = exp_wr;
  endtask

  // Runs one program: start at cycle 0, optional abort / misuse cycles, samples at negedge.
  task automatic run(input int ncyc, input int abort_at, input int misuse_at,
                     input logic [46:0] mis_ent, input int last_busy);
    logic [14:0] pa;
    logic [31:0] pd;
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
    obs_done.delete(); obs_rej.delete();
    busy_bad = 0;
    hold_bad = 0;
    pa = 15'd0;
    pd = 32'd0;
    for (int c = 0; c < ncyc; c++) begin
      start_i    = (c == 0) || (c == misuse_at);
      abort_i    = (c == abort_at);
      ld_write_i = (c == misuse_at);
      if (c == misuse_at) begin
        ld_addr_i    = '0;
        ld_lb_addr_i = mis_ent[46:32];
        ld_lb_data_i = mis_ent[31:0];
      end
      @(negedge clk);
      if (lb_if.lb_write) begin
        obs_cyc.push_back(c);
        obs_addr.push_back(lb_if.lb_addr);
        obs_data.push_back(lb_if.lb_data);
      end else if (c > 0 && (lb_if.lb_addr !== pa || lb_if.lb_data !== pd)) begin
        hold_bad++;
      end
      pa = lb_if.lb_addr;
      pd = lb_if.lb_data;
      if (done_o) obs_done.push_back(c);
      if (ld_reject_o) obs_rej.push_back(c);
      if (busy_o !== ((c >= 1) && (c <= last_busy))) busy_bad++;
      @(posedge clk); #1;
    end
    start_i    = 1'b0;
    abort_i    = 1'b0;
    ld_write_i = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int bad = 0;
    int n;
    chk({tag, ":n_wr"}, obs_cyc.size(), exp_cyc.size());
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      if (obs_cyc[i] != exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
    end
    chk({tag, ":strobe_bad"}, bad, 0);
    chk({tag, ":n_done"}, obs_done.size(), (exp_done < 0) ? 0 : 1);
    chk({tag, ":done_cyc"}, (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
    chk({tag, ":busy_bad"}, busy_bad, 0);
    chk({tag, ":wr_count"}, 64'(wr_count_o), 64'(exp_wr));
    chk({tag, ":n_rej"}, obs_rej.size(), (exp_rej < 0) ? 0 : 1);
    chk({tag, ":rej_cyc"}, (obs_rej.size() > 0) ? obs_rej[0] : -1, exp_rej);
    chk({tag, ":hold_bad"}, hold_bad, 0);
  endtask

  task automatic load_full();
    for (int i = 0; i < DEPTH; i++) load(i, 15'(100 + i), 32'hC0DE_0000 + 32'(i));
  endtask

  initial begin
    tbl[0] = '{15'd7,   32'h0000_0033, 3, 9,  12};
    tbl[1] = '{STALL,   32'd10,        2, 18, 21};
    tbl[2] = '{STALL,   32'd0,         2, 8,  11};
    tbl[3] = '{STALL,   32'd1,         2, 9,  12};
    tbl[4] = '{ENDA,    32'd0,         1, 3,  6};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ld_write_i = 1'b0;
    ld_addr_i = '0; ld_lb_addr_i = 15'd0; ld_lb_data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", 64'(busy_o), 64'd0);
    chk("rst:done", 64'(done_o), 64'd0);
    chk("rst:ld_reject", 64'(ld_reject_o), 64'd0);
    chk("rst:lb_write", 64'(lb_if.lb_write), 64'd0);
    chk("rst:lb_addr", 64'(lb_if.lb_addr), 64'd0);
    chk("rst:lb_data", 64'(lb_if.lb_data), 64'd0);
    chk("rst:wr_count", 64'(wr_count_o), 64'd0);
    rst = 1'b0;

    // Table vectors: write, middle entry, write, END.
    for (int v = 0; v < 5; v++) begin
      load(0, 15'd5, 32'hA5A5_0001);
      load(1, tbl[v].mid_addr, tbl[v].mid_data);
      load(2, 15'd6, 32'h0000_00B2);
      load(3, ENDA, 32'd0);
      run(40, -1, -1, 47'd0, tbl[v].done_cyc);
      chk($sformatf("tbl%0d:n_wr", v), obs_cyc.size(), tbl[v].n_wr);
      chk($sformatf("tbl%0d:last_wr_cyc", v),
          (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : -1, tbl[v].last_wr_cyc);
      chk($sformatf("tbl%0d:first_data", v),
          (obs_data.size() > 0) ? 64'(obs_data[0]) : 64'd0, 64'h0000_0000_A5A5_0001);
      chk($sformatf("tbl%0d:done_cyc", v),
          (obs_done.size() == 1) ? obs_done[0] : -1, tbl[v].done_cyc);
      chk($sformatf("tbl%0d:busy_bad", v), busy_bad, 0);
      chk($sformatf("tbl%0d:wr_count", v), 64'(wr_count_o), 64'(tbl[v].n_wr));
    end

    // Full table without END: eight writes, done after the last, no wrap.
    load_full();
    model(-1, -1, 47'd0);
    run(40, -1, -1, 47'd0, exp_last_busy);
    check_model("full");
    chk("full:done_cyc_hand", (obs_done.size() > 0) ? obs_done[0] : -1, 25);

    // Misuse while busy: start and ld_write mid-run are ignored, one reject pulse.
    model(-1, 5, {15'h1ff, 32'hDEAD_BEEF});
    run(40, -1, 5, {15'h1ff, 32'hDEAD_BEEF}, exp_last_busy);
    check_model("misuse");
    model(-1, -1, 47'd0);
    run(40, -1, -1, 47'd0, exp_last_busy);
    check_model("rerun");

    // Abort in the cycle of the third strobe.
    model(9, -1, 47'd0);
    run(40, 9, -1, 47'd0, exp_last_busy);
    check_model("abort");
    chk("abort:wr_hand", 64'(wr_count_o), 64'd3);

    // start and abort together while idle: nothing starts, wr_count holds.
    model(0, -1, 47'd0);
    run(12, 0, -1, 47'd0, exp_last_busy);
    check_model("start_abort");

    // ld_write and start together while idle: the new entry 0 is what runs.
    model(-1, 0, {15'h2aa, 32'h1234_5678});
    run(40, -1, 0, {15'h2aa, 32'h1234_5678}, exp_last_busy);
    check_model("ld_start");

    // Randomized programs with optional abort.
    for (int it = 0; it < 20; it++) begin
      int k, ab;
      for (int i = 0; i < DEPTH; i++) begin
        logic [14:0] ra;
        k = $urandom_range(0, 99);
        if (k < 15) begin
          load(i, ENDA, $urandom());
        end else if (k < 40) begin
          load(i, STALL, 32'($urandom_range(0, 5)));
        end else begin
          ra = 15'($urandom_range(0, 32766));
          if (ra == STALL) ra = 15'd556;
          load(i, ra, $urandom());
        end
      end
      ab = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 40));
      model(ab, -1, 47'd0);
      run(70, ab, -1, 47'd0, exp_last_busy);
      check_model($sformatf("rand%0d", it));
    end

    // Reset in the middle of a run zeroes every output.
    load_full();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid:busy", 64'(busy_o), 64'd0);
    chk("rst_mid:done", 64'(done_o), 64'd0);
    chk("rst_mid:lb_write", 64'(lb_if.lb_write), 64'd0);
    chk("rst_mid:lb_addr", 64'(lb_if.lb_addr), 64'd0);
    chk("rst_mid:lb_data", 64'(lb_if.lb_data), 64'd0);
    chk("rst_mid:wr_count", 64'(wr_count_o), 64'd0);
    chk("rst_mid:ld_reject", 64'(ld_reject_o), 64'd0);
    rst = 1'b0;
    prev_wr = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
